// File: rtl/regfile_dump_tx.sv
// ============================================================================
// Module   : regfile_dump_tx
// Purpose  : On request, read every CPU register through a dedicated
//            asynchronous read port and stream the values out on an 8N1
//            serial line: header 0xA5, then per register an index byte
//            followed by four data bytes, MSB first.
// Options  : DUMP_CHECKSUM_EN - append a modulo-256 sum of all bytes after
//            the header as a final frame byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int NUM_REGS     = 32,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dump_req,
    output logic [4:0]      rf_raddr,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            tx,
    output logic            busy,
    output logic            done
);

    localparam int                    c_baud_w    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_baud_w-1:0]   c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0]   c_baud_one  = c_baud_w'(1);
    localparam logic [4:0]            c_last_reg  = 5'(NUM_REGS - 1);
    localparam logic [7:0]            c_header    = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_IDX  = 3'd3,
        ST_DATA = 3'd4,
        ST_CHK  = 3'd5,
        ST_END  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        B_START = 2'd0,
        B_BITS  = 2'd1,
        B_STOP  = 2'd2
    } bstate_t;

    state_t                r_state;
    bstate_t               r_bstate;
    logic [c_baud_w-1:0]   r_baud;
    logic [2:0]            r_bit;
    logic [7:0]            r_shift;
    logic [4:0]            r_reg;
    logic [1:0]            r_k;
    logic [XLEN-1:0]       r_shadow;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]            r_sum;
`endif

    logic                  w_sending;
    logic                  w_bit_end;
    logic                  w_byte_end;
    logic [7:0]            w_next_data;

    // Decode when a serial byte is in flight and when its last bit ends
    always_comb begin
        w_sending  = (r_state == ST_HDR) || (r_state == ST_IDX) ||
                     (r_state == ST_DATA) || (r_state == ST_CHK);
        w_bit_end  = (r_baud == c_baud_last);
        w_byte_end = w_sending && w_bit_end && (r_bstate == B_STOP);
    end

    // Select the shadow byte that follows the one currently being sent
    always_comb begin
        w_next_data = r_shadow[7:0];
        case (r_k)
            2'd0:    w_next_data = r_shadow[23:16];
            2'd1:    w_next_data = r_shadow[15:8];
            default: w_next_data = r_shadow[7:0];
        endcase
    end

    // Frame sequencer and bit serializer with registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_bstate <= B_START;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_reg    <= '0;
            r_k      <= '0;
            r_shadow <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            r_sum    <= '0;
`endif
        end else begin
            r_done <= 1'b0;

            // Baud counter and bit stepping inside a byte
            if (w_sending) begin
                if (!w_bit_end) begin
                    r_baud <= r_baud + c_baud_one;
                end else begin
                    r_baud <= '0;
                    case (r_bstate)
                        B_START: begin
                            r_bstate <= B_BITS;
                            r_bit    <= 3'd0;
                            r_tx     <= r_shift[0];
                        end
                        B_BITS: begin
                            if (r_bit == 3'd7) begin
                                r_bstate <= B_STOP;
                                r_tx     <= 1'b1;
                            end else begin
                                r_bit   <= r_bit + 3'd1;
                                r_shift <= {1'b0, r_shift[7:1]};
                                r_tx    <= r_shift[1];
                            end
                        end
                        default: begin
                            // Stop bit end is handled by the frame sequencer
                        end
                    endcase
                end
            end

            // Frame-level sequencing; a new byte always starts with its start bit
            case (r_state)
                ST_IDLE: begin
                    if (dump_req) begin
                        r_state  <= ST_HDR;
                        r_busy   <= 1'b1;
                        r_reg    <= '0;
                        r_bstate <= B_START;
                        r_baud   <= '0;
                        r_shift  <= c_header;
                        r_tx     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        r_sum    <= '0;
`endif
                    end
                end
                ST_HDR: begin
                    if (w_byte_end) begin
                        r_state <= ST_LOAD;
                        r_tx    <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // rf_raddr already equals r_reg; snapshot the register now
                    r_shadow <= rf_rdata;
                    r_state  <= ST_IDX;
                    r_bstate <= B_START;
                    r_baud   <= '0;
                    r_shift  <= {3'b000, r_reg};
                    r_tx     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                    r_sum    <= r_sum + {3'b000, r_reg};
`endif
                end
                ST_IDX: begin
                    if (w_byte_end) begin
                        r_state  <= ST_DATA;
                        r_k      <= 2'd0;
                        r_bstate <= B_START;
                        r_shift  <= r_shadow[31:24];
                        r_tx     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        r_sum    <= r_sum + r_shadow[31:24];
`endif
                    end
                end
                ST_DATA: begin
                    if (w_byte_end) begin
                        if (r_k != 2'd3) begin
                            r_k      <= r_k + 2'd1;
                            r_bstate <= B_START;
                            r_shift  <= w_next_data;
                            r_tx     <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                            r_sum    <= r_sum + w_next_data;
`endif
                        end else if (r_reg == c_last_reg) begin
`ifdef DUMP_CHECKSUM_EN
                            r_state  <= ST_CHK;
                            r_bstate <= B_START;
                            r_shift  <= r_sum;
                            r_tx     <= 1'b0;
`else
                            r_state  <= ST_END;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_tx     <= 1'b1;
`endif
                        end else begin
                            r_reg   <= r_reg + 5'd1;
                            r_state <= ST_LOAD;
                            r_tx    <= 1'b1;
                        end
                    end
                end
                ST_CHK: begin
                    if (w_byte_end) begin
                        r_state <= ST_END;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_tx    <= 1'b1;
                    end
                end
                ST_END: begin
                    // dump_req is deliberately not sampled here
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rf_raddr = r_reg;
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: doc/regfile_dump_tx.md
Name: regfile_dump_tx

Overview:
- Hardware counterpart of the bench-side register check. On request, reads the CPU register file through a dedicated asynchronous read port and streams every register out on a UART-style 8N1 serial line.
- Sits beside the single-cycle core's register file. Gives silicon/FPGA builds the same end-of-run visibility of x0..x31 that simulation gets from hierarchical access.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (>=2)
- NUM_REGS, 32, registers dumped, indices 0..NUM_REGS-1 (<=32)
- XLEN, 32, register width; must be 32 (4 bytes per register)

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low
- dump_req  input  1  start pulse; sampled only in IDLE
- rf_raddr  output  5  register file read address
- rf_rdata  input  32  register file read data; combinational, valid same cycle as rf_raddr
- tx  output  1  serial out; idle high
- busy  output  1  high from the cycle after dump_req is accepted until done
- done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (rst==0 at posedge): tx=1, busy=0, done=0, rf_raddr=0, all counters 0, FSM=IDLE. Mid-frame reset aborts immediately; no partial byte or stop bit is completed.
- Frame format, in transmission order:
  - header byte 0xA5
  - for r = 0..NUM_REGS-1: index byte r, then rf[r] as 4 bytes MSB first (bits 31:24, 23:16, 15:8, 7:0)
  - x0 is included and is sent as 0x00000000
- Byte encoding (8N1): start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles, so one byte = 10*CLKS_PER_BIT cycles. Bytes are sent back-to-back with no idle gap.
- Top FSM:
  - IDLE: busy=0, tx=1. dump_req=1 -> HDR. busy rises next cycle, and the start bit of 0xA5 appears on tx that same cycle.
  - HDR: send 0xA5 -> LOAD.
  - LOAD: drive rf_raddr=r and capture rf_rdata into a 32-bit shadow register at the end of that one cycle -> IDX. The cycle is inserted between bytes, so there is a one-cycle tx-high gap before each index byte.
  - IDX: send r -> DATA with byte counter 0.
  - DATA: send shadow byte k; k=3 -> LOAD with r+1, or END if r==NUM_REGS-1.
  - END: done=1 for one cycle, busy=0 the same cycle -> IDLE.
- Data is snapshotted per register. Register writes by the core after that register's LOAD cycle are not reflected in the frame.
- Byte sub-FSM: START, BITS (3-bit bit counter), STOP, with a baud counter 0..CLKS_PER_BIT-1 that wraps and advances the bit on the terminal count.
- dump_req while busy is ignored; there is no queueing. dump_req in the END cycle is ignored. dump_req held high re-triggers from IDLE on the cycle after END.
- Register counter r is 5 bits. Termination is by compare with NUM_REGS-1; no wrap past it.
- Cycle budget with defaults: total = 161 bytes*160 + 32 LOAD cycles = 25792 cycles from busy rise to the done pulse (inclusive of the done cycle).

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined: after the last data byte, one extra byte is sent before END. Its value is the 8-bit modulo-256 sum of every byte after the header (indices and data). The frame becomes 162 bytes; the default budget becomes 25952 cycles.
- Undefined: no checksum byte, no accumulator logic; frame exactly as above.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-frame (after ~1000 cycles of a dump) -> next cycle tx=1, busy=0, done=0; a new dump_req afterwards produces a clean frame starting with 0xA5.
- Basic dump: preload rf[3]=5, rf[4]=7, rf[5]=12, others 0; pulse dump_req -> a UART monitor decodes 0xA5, then "00 00000000", "01 00000000", ..., "03 00000005", "04 00000007", "05 0000000C", ..., 32 records total; done pulses exactly once.
- Timing: CLKS_PER_BIT=16 -> start bit of header begins the cycle busy rises; each bit lasts 16 cycles; busy-high to done measured as 25792 cycles (25952 with DUMP_CHECKSUM_EN).
- Ignore while busy: pulse dump_req again 500 cycles into a frame -> frame unchanged; exactly one done pulse; tx idle high after done until a new request.
- Snapshot: change rf[10] from 0x11111111 to 0x22222222 after its LOAD cycle -> frame reports 0x11111111 for index 10; change rf[20] before index 20 is loaded -> 0x22222222 reported.
- Checksum (DUMP_CHECKSUM_EN): rf[1]=0x000000FF, others 0 -> final byte = (sum of indices 0..31 = 496) + 0xFF = 751 mod 256 = 0xEF.
